// File: rtl/min_search_pkg.sv
// Shared types and defaults for the minimum-search controller.
// The MIN_SEARCH_CAP_EN build uses cap_beats() to size its beat cap.
package min_search_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int DATA_W_DEF    = 18;
   localparam int POS_W_DEF     = 6;
   localparam int CAP_BEATS_DEF = 1 << POS_W_DEF;

   // Largest number of beats one search may take when the cap is built in.
   function automatic int cap_beats(input int pos_w);
      return 1 << pos_w;
   endfunction

endpackage

// File: rtl/min_search_ctrl_if.sv
// Candidate stream: valid/ready handshake carrying (distance, position, last).
// The master modport is the distance generator; the slave modport is the controller.
interface min_search_ctrl_if #(
   parameter int DATA_W = 18,
   parameter int POS_W  = 6
);
   logic              cand_valid;
   logic              cand_ready;
   logic [DATA_W-1:0] cand_data;
   logic [POS_W-1:0]  cand_pos;
   logic              cand_last;

   modport master (
      output cand_valid, cand_data, cand_pos, cand_last,
      input  cand_ready
   );

   modport slave (
      input  cand_valid, cand_data, cand_pos, cand_last,
      output cand_ready
   );
endinterface

// File: rtl/min_cmp_stage.sv
// Single two-input compare stage: picks the running best or the new candidate.
// Strict less-than, so on a tie the earlier position is kept.
module min_cmp_stage #(
   parameter int DATA_W = 18,
   parameter int POS_W  = 6
) (
   input  logic              first,
   input  logic [DATA_W-1:0] best_data,
   input  logic [POS_W-1:0]  best_pos,
   input  logic [DATA_W-1:0] cand_data,
   input  logic [POS_W-1:0]  cand_pos,
   output logic [DATA_W-1:0] sel_data,
   output logic [POS_W-1:0]  sel_pos,
   output logic              replace
);

   assign replace  = first | (cand_data < best_data);
   assign sel_data = replace ? cand_data : best_data;
   assign sel_pos  = replace ? cand_pos  : best_pos;

endmodule

// File: rtl/min_search_ctrl.sv
// Restartable sequential minimum search over a valid/ready candidate stream.
// Optional MIN_SEARCH_CAP_EN: ends a search after 2**POS_W beats and flags cand_overflow.
module min_search_ctrl
   import min_search_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int POS_W  = POS_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   min_search_ctrl_if.slave  cand,
   output logic              busy,
   output logic              done,
   output logic              best_valid,
   output logic [DATA_W-1:0] best_data,
   output logic [POS_W-1:0]  best_pos
`ifdef MIN_SEARCH_CAP_EN
   ,
   output logic              cand_overflow
`endif
);

   state_t            state;
   logic              first;
   logic              rdy_q;
   logic              accept;
   logic              end_beat;
   logic [DATA_W-1:0] sel_data;
   logic [POS_W-1:0]  sel_pos;
   logic              replace;

   // Ready is registered and depends only on state, never on cand_valid.
   assign cand.cand_ready = rdy_q;
   assign accept          = (state == SEARCH) & cand.cand_valid & rdy_q;

   min_cmp_stage #(
      .DATA_W (DATA_W),
      .POS_W  (POS_W)
   ) u_cmp (
      .first     (first),
      .best_data (best_data),
      .best_pos  (best_pos),
      .cand_data (cand.cand_data),
      .cand_pos  (cand.cand_pos),
      .sel_data  (sel_data),
      .sel_pos   (sel_pos),
      .replace   (replace)
   );

`ifdef MIN_SEARCH_CAP_EN
   localparam int                 CAP  = cap_beats(POS_W);
   localparam logic [POS_W:0]     LAST_CNT = (POS_W+1)'(CAP - 1);
   logic [POS_W:0] beat_cnt;
   logic           cap_hit;

   // This beat is the CAP-th accepted one of the search.
   assign cap_hit  = (beat_cnt == LAST_CNT) & ~cand.cand_last;
   assign end_beat = cand.cand_last | cap_hit;
`else
   assign end_beat = cand.cand_last;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         first      <= 1'b0;
         rdy_q      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         best_valid <= 1'b0;
         best_data  <= '0;
         best_pos   <= '0;
`ifdef MIN_SEARCH_CAP_EN
         beat_cnt      <= '0;
         cand_overflow <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (start) begin
            // Restart wins over any beat presented in the same cycle.
            state      <= SEARCH;
            first      <= 1'b1;
            rdy_q      <= 1'b1;
            busy       <= 1'b1;
            best_valid <= 1'b0;
            best_data  <= '0;
            best_pos   <= '0;
`ifdef MIN_SEARCH_CAP_EN
            beat_cnt      <= '0;
            cand_overflow <= 1'b0;
`endif
         end else begin
            case (state)
               SEARCH: begin
                  if (accept) begin
                     best_data <= sel_data;
                     best_pos  <= sel_pos;
                     first     <= 1'b0;
`ifdef MIN_SEARCH_CAP_EN
                     beat_cnt  <= beat_cnt + 1'b1;
                     if (cap_hit) cand_overflow <= 1'b1;
`endif
                     if (end_beat) begin
                        state      <= DONE;
                        rdy_q      <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        best_valid <= 1'b1;
                     end
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  rdy_q <= 1'b0;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_min_search_ctrl.sv
// Scoreboard bench for min_search_ctrl: directed searches push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_min_search_ctrl;

   localparam int DW = 18;
   localparam int PW = 6;

   typedef struct {
      logic [DW-1:0] d;
      logic [PW-1:0] p;
      logic          ovf;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          busy;
   logic          done;
   logic          best_valid;
   logic [DW-1:0] best_data;
   logic [PW-1:0] best_pos;
`ifdef MIN_SEARCH_CAP_EN
   logic          cand_overflow;
`endif

   int   checks = 0;
   int   passed = 0;
   exp_t q[$];
   logic prev_done = 1'b0;

   min_search_ctrl_if #(.DATA_W(DW), .POS_W(PW)) cif ();

   min_search_ctrl #(.DATA_W(DW), .POS_W(PW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cand       (cif),
      .busy       (busy),
      .done       (done),
      .best_valid (best_valid),
      .best_data  (best_data),
      .best_pos   (best_pos)
`ifdef MIN_SEARCH_CAP_EN
      ,
      .cand_overflow (cand_overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         exp_t e;
         chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("best_data", 32'(best_data), 32'(e.d));
            chk("best_pos", 32'(best_pos), 32'(e.p));
            chk("best_valid", {31'd0, best_valid}, 32'd1);
            chk("busy_in_done", {31'd0, busy}, 32'd0);
            chk("ready_in_done", {31'd0, cif.cand_ready}, 32'd0);
`ifdef MIN_SEARCH_CAP_EN
            chk("cand_overflow", {31'd0, cand_overflow}, {31'd0, e.ovf});
`endif
         end
      end
      prev_done <= done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Present one beat for one cycle; cand_ready must already be high.
   task automatic beat(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic last);
      cif.cand_valid = 1'b1;
      cif.cand_data  = d;
      cif.cand_pos   = p;
      cif.cand_last  = last;
      chk("ready_when_beat", {31'd0, cif.cand_ready}, 32'd1);
      tick();
   endtask

   task automatic idle(input int n);
      cif.cand_valid = 1'b0;
      cif.cand_last  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic push(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic ovf);
      exp_t e;
      e.d = d; e.p = p; e.ovf = ovf;
      q.push_back(e);
   endtask

   initial begin
      rst_n          = 1'b0;
      start          = 1'b0;
      cif.cand_valid = 1'b1;
      cif.cand_data  = 18'h00055;
      cif.cand_pos   = 6'd9;
      cif.cand_last  = 1'b1;
      repeat (3) tick();
      chk("rst_ready", {31'd0, cif.cand_ready}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_best_valid", {31'd0, best_valid}, 32'd0);
      chk("rst_best_data", 32'(best_data), 32'd0);
      chk("rst_best_pos", 32'(best_pos), 32'd0);
      rst_n = 1'b1;
      idle(2);
      chk("idle_ready", {31'd0, cif.cand_ready}, 32'd0);

      // Basic search: minimum in the middle.
      pulse_start();
      chk("start_busy", {31'd0, busy}, 32'd1);
      push(18'd12, 6'd2, 1'b0);
      beat(18'd40, 6'd1, 1'b0);
      beat(18'd12, 6'd2, 1'b0);
      beat(18'd30, 6'd3, 1'b1);
      idle(3);
      chk("hold_best_data", 32'(best_data), 32'd12);
      chk("hold_best_valid", {31'd0, best_valid}, 32'd1);
      chk("hold_done_low", {31'd0, done}, 32'd0);

      // Tie keeps earlier position.
      pulse_start();
      chk("restart_clears_valid", {31'd0, best_valid}, 32'd0);
      push(18'd7, 6'd5, 1'b0);
      beat(18'd7, 6'd5, 1'b0);
      beat(18'd7, 6'd9, 1'b1);
      idle(2);

      // Single beat at full scale.
      pulse_start();
      push(18'h3FFFF, 6'd63, 1'b0);
      beat(18'h3FFFF, 6'd63, 1'b1);
      idle(2);

      // Restart mid-search; the beat in the start cycle is discarded.
      pulse_start();
      beat(18'd3, 6'd1, 1'b0);
      cif.cand_valid = 1'b1;
      cif.cand_data  = 18'd1;
      cif.cand_pos   = 6'd7;
      cif.cand_last  = 1'b0;
      pulse_start();
      push(18'd20, 6'd4, 1'b0);
      beat(18'd20, 6'd4, 1'b0);
      beat(18'd25, 6'd6, 1'b1);
      idle(2);

      // Start coincident with a last beat: start wins, no done.
      pulse_start();
      beat(18'd9, 6'd1, 1'b0);
      cif.cand_valid = 1'b1;
      cif.cand_data  = 18'd2;
      cif.cand_pos   = 6'd2;
      cif.cand_last  = 1'b1;
      pulse_start();
      chk("coinc_busy", {31'd0, busy}, 32'd1);
      chk("coinc_no_done", {31'd0, done}, 32'd0);
      chk("coinc_ready", {31'd0, cif.cand_ready}, 32'd1);
      push(18'd50, 6'd3, 1'b0);
      beat(18'd50, 6'd3, 1'b0);
      beat(18'd60, 6'd8, 1'b1);
      idle(2);

      // 64 beats without last: minimum at beat 20.
      pulse_start();
`ifdef MIN_SEARCH_CAP_EN
      push(18'd10, 6'd20, 1'b1);
`endif
      for (int i = 0; i < 64; i++)
         beat((i == 20) ? 18'd10 : 18'(100 + i), 6'(i), 1'b0);
`ifdef MIN_SEARCH_CAP_EN
      idle(3);
      chk("cap_idle_busy", {31'd0, busy}, 32'd0);
`else
      idle(1);
      chk("nocap_busy", {31'd0, busy}, 32'd1);
      chk("nocap_no_done", {31'd0, done}, 32'd0);
      chk("nocap_best_data", 32'(best_data), 32'd10);
      push(18'd10, 6'd20, 1'b0);
      beat(18'd50, 6'd0, 1'b1);
      idle(3);
`endif

      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
